uart_word_tx: RTL and testbench

UART_WORD_TX -- requirements
Module: uart_word_tx

---
 rtl/uart_word_tx.sv | 123 ++++++++++++
 tb/tb_uart_word_tx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// 8N1 UART transmitter: serializes a BYTES-wide word, least-significant byte first,
// with back-to-back bytes of a word sent without any idle gap.
module uart_word_tx #(
  parameter int unsigned BYTES        = 1,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BYTES*8-1:0] i_data,
  input  logic               i_valid,
  output logic               i_ready,
  output logic               uart_txd,
  output logic               o_busy
);

  localparam int unsigned      ByteW    = $clog2(BYTES) + 1;
  localparam int unsigned      WordW    = BYTES * 8;
  localparam logic [15:0]      BaudMax  = 16'(CLKS_PER_BIT - 1);
  localparam logic [ByteW-1:0] LastByte = ByteW'(BYTES - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           state_q, state_d;
  logic [15:0]      baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [ByteW-1:0] byte_q, byte_d;
  logic [WordW-1:0] shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             bit_end;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    bit_end = (baud_q == BaudMax);

    // The baud counter reloads at every bit boundary so each bit lasts CLKS_PER_BIT cycles.
    if (state_q != StIdle) begin
      baud_d = bit_end ? '0 : baud_q + 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (i_valid && ready_q) begin
          state_d = StStart;
          shift_d = i_data;
          txd_d   = 1'b0;
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          txd_d   = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          // After eight shifts the next byte of the word sits in the low bits.
          shift_d = {1'b0, shift_q[WordW-1:1]};
          if (bit_q == 3'd7) begin
            state_d = StStop;
            txd_d   = 1'b1;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = shift_q[1];
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          if (byte_q == LastByte) begin
            state_d = StIdle;
            txd_d   = 1'b1;
          end else begin
            state_d = StStart;
            byte_d  = byte_q + ByteW'(1);
            txd_d   = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle);
    busy_d  = ~ready_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign i_ready  = ready_q;
  assign uart_txd = txd_q;
  assign o_busy   = busy_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: a one-byte and a two-byte instance, a UART receiver monitor per
// instance that decodes frames and checks them against a queue of expected bytes.
module tb_uart_word_tx;

  localparam int unsigned Cpb = 4;

  logic        clk;
  logic        rst1, rst2;
  logic [7:0]  d1;
  logic [15:0] d2;
  logic        v1, v2;
  logic        ready1, ready2, txd1, txd2, busy1, busy2;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          acc_cyc;
  bit          mon_en [2];
  int          last_start [2];
  int          prev_start [2];
  logic [7:0]  exp0 [$];
  logic [7:0]  exp1 [$];

  uart_word_tx #(.BYTES(1), .CLKS_PER_BIT(Cpb)) u_dut1 (
    .clk     (clk),
    .rst     (rst1),
    .i_data  (d1),
    .i_valid (v1),
    .i_ready (ready1),
    .uart_txd(txd1),
    .o_busy  (busy1)
  );

  uart_word_tx #(.BYTES(2), .CLKS_PER_BIT(Cpb)) u_dut2 (
    .clk     (clk),
    .rst     (rst2),
    .i_data  (d2),
    .i_valid (v2),
    .i_ready (ready2),
    .uart_txd(txd2),
    .o_busy  (busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic line(input int id);
    return (id == 0) ? txd1 : txd2;
  endfunction

  function automatic logic rdy(input int id);
    return (id == 0) ? ready1 : ready2;
  endfunction

  function automatic logic in_rst(input int id);
    return (id == 0) ? rst1 : rst2;
  endfunction

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, expv);
    end
  endtask

  // Receiver: every bit must hold for exactly Cpb samples; decoded byte is checked against queue.
  task automatic monitor(input int id);
    logic [9:0] bits;
    logic       s;
    logic       ok;
    logic [7:0] e;
    forever begin
      @(posedge clk); #1;
      if (mon_en[id] && !in_rst(id) && line(id) === 1'b0) begin
        prev_start[id] = last_start[id];
        last_start[id] = cyc;
        ok = 1'b1;
        s  = 1'b0;
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < int'(Cpb); k++) begin
            if (b != 0 || k != 0) begin
              @(posedge clk); #1;
            end
            if (k == 0) s = line(id);
            else if (line(id) !== s) ok = 1'b0;
          end
          bits[b] = s;
        end
        checks++;
        if ((id == 0 && exp0.size() == 0) || (id == 1 && exp1.size() == 0)) begin
          errors++;
          $display("FAIL frame dut%0d: got unexpected byte %02h, required no frame", id, bits[8:1]);
        end else begin
          e = (id == 0) ? exp0.pop_front() : exp1.pop_front();
          if (!ok || bits[0] !== 1'b0 || bits[9] !== 1'b1 || bits[8:1] !== e) begin
            errors++;
            $display("FAIL frame dut%0d: got bits %010b (stable=%0b), required byte %02h", id,
                     bits, ok, e);
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic send(input int id, input logic [15:0] d, input bit push);
    int n;
    if (id == 0) begin
      d1 = d[7:0];
      v1 = 1'b1;
    end else begin
      d2 = d;
      v2 = 1'b1;
    end
    n = 0;
    while (rdy(id) !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout dut%0d: ready=%b, required 1", id, rdy(id));
    end else if (push) begin
      if (id == 0) exp0.push_back(d[7:0]);
      else begin
        exp1.push_back(d[7:0]);
        exp1.push_back(d[15:8]);
      end
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    // Scramble the input word while busy; the frame must not change.
    if (id == 0) begin
      v1 = 1'b0;
      d1 = 8'($urandom);
    end else begin
      v2 = 1'b0;
      d2 = 16'($urandom);
    end
  endtask

  task automatic wait_ready(input int id, input int budget, output int n, output int bad);
    n   = 0;
    bad = 0;
    while (rdy(id) !== 1'b1 && n < budget) begin
      if (((id == 0) ? busy1 : busy2) !== 1'b1) bad++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation still running after 90000 cycles, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad;
    mon_en[0] = 1'b1;
    mon_en[1] = 1'b1;
    rst1 = 1'b1;
    rst2 = 1'b1;
    // A word offered during reset must be ignored.
    v1 = 1'b1;
    d1 = 8'h5A;
    v2 = 1'b1;
    d2 = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd1", txd1, 1);
    chk("rst_ready1", ready1, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_txd2", txd2, 1);
    chk("rst_ready2", ready2, 0);
    v1 = 1'b0;
    v2 = 1'b0;
    rst1 = 1'b0;
    rst2 = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready1", ready1, 1);
    chk("post_rst_busy1", busy1, 0);
    chk("post_rst_ready2", ready2, 1);

    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (txd1 !== 1'b1 || ready1 !== 1'b1 || busy1 !== 1'b0 || txd2 !== 1'b1) bad++;
    end
    chk("idle_100", bad, 0);

    // Single byte 0x55: 40 cycles on the line, then ready.
    send(0, 16'h0055, 1'b1);
    chk("accept_txd_low", txd1, 0);
    wait_ready(0, 200, n, bad);
    chk("b1_len", n, 40);
    chk("b1_busy_held", bad, 0);
    chk("b1_txd_idle", txd1, 1);
    chk("b1_busy_end", busy1, 0);

    // Two-byte word 0xA5C3: C3 then A5, 80 cycles, no gap between bytes.
    send(1, 16'hA5C3, 1'b1);
    wait_ready(1, 300, n, bad);
    chk("b2_len", n, 80);
    chk("b2_busy_held", bad, 0);
    chk("b2_no_gap", last_start[1] - prev_start[1], 40);

    // Valid held high: 0x01 then 0xFF, data changed mid-frame, one idle cycle between words.
    exp0.push_back(8'h01);
    exp0.push_back(8'hFF);
    d1 = 8'h01;
    v1 = 1'b1;
    @(posedge clk); #1;
    d1 = 8'hFF;
    wait_ready(0, 200, n, bad);
    @(posedge clk); #1;
    v1 = 1'b0;
    d1 = 8'h3C;
    wait_ready(0, 200, n, bad);
    chk("b2b_len", n, 40);
    chk("b2b_gap", last_start[0] - prev_start[0], 41);

    // Reset at cycle 15 of a 0x00 frame aborts it.
    mon_en[0] = 1'b0;
    send(0, 16'h0000, 1'b0);
    repeat (14) begin
      @(posedge clk); #1;
    end
    rst1 = 1'b1;
    @(posedge clk); #1;
    chk("abort_txd", txd1, 1);
    chk("abort_ready", ready1, 0);
    chk("abort_busy", busy1, 0);
    rst1 = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready_after", ready1, 1);
    bad = 0;
    repeat (50) begin
      if (txd1 !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    chk("abort_line_high", bad, 0);
    mon_en[0] = 1'b1;

    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 4)) begin
            @(posedge clk); #1;
          end
          send(0, 16'($urandom), 1'b1);
        end
      end
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 6)) begin
            @(posedge clk); #1;
          end
          send(1, 16'($urandom), 1'b1);
        end
      end
    join
    repeat (100) begin
      @(posedge clk); #1;
    end
    chk("rand_drain1", exp0.size(), 0);
    chk("rand_drain2", exp1.size(), 0);
    chk("rand_ready1", ready1, 1);
    chk("rand_ready2", ready2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
